// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, a read-valid strobe and
// sticky overflow/underflow flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode:
// a one-entry head register (counted in count_o) always shows the oldest word.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en_in,
    input  logic                  err_clr_in,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] LP_ONE   = CW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_wr_ptr, r_rd_ptr, r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rd_valid;
    logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_unf;

    logic                  w_wr_acc, w_rd_acc;
    logic                  w_mem_wr, w_mem_rd;
    logic [CW-1:0]         w_cnt_nxt;

    // Acceptance is judged on the registered (pre-edge) flags only.
    assign w_wr_acc = wr_en_in & ~r_full;
    assign w_rd_acc = rd_en_in & ~r_empty;

`ifdef SYNC_FIFO_FWFT_EN
    logic w_mem_empty, w_head_free, w_bypass;

    // Head register is refilled whenever it is empty or being popped; memory
    // feeds it first, otherwise a write into an empty array bypasses memory.
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head_free = ~r_rd_valid | w_rd_acc;
    assign w_mem_rd    = w_head_free & ~w_mem_empty;
    assign w_bypass    = w_head_free & w_mem_empty & w_wr_acc;
    assign w_mem_wr    = w_wr_acc & ~w_bypass;
`else
    assign w_mem_wr = w_wr_acc;
    assign w_mem_rd = w_rd_acc;
`endif

    assign w_cnt_nxt = r_count
                     + (w_wr_acc ? LP_ONE : '0)
                     - (w_rd_acc ? LP_ONE : '0);

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (w_mem_wr) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    // Wrap-bit pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_mem_wr) r_wr_ptr <= r_wr_ptr + LP_ONE;
            if (w_mem_rd) r_rd_ptr <= r_rd_ptr + LP_ONE;
            r_count <= w_cnt_nxt;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head register: r_rd_valid marks it occupied, which tracks ~empty_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_head_free) begin
            if (w_mem_rd) begin
                r_data     <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_rd_valid <= 1'b1;
            end else if (w_bypass) begin
                r_data     <= data_in;
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end
`else
    // Registered read port: one-cycle latency, data held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_mem_rd;
            if (w_mem_rd) r_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end
`endif

    // Status flags registered from the next count so they match count_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            r_full  <= (w_cnt_nxt == LP_DEPTH);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= LP_AF);
            r_ae    <= (w_cnt_nxt <= LP_AE);
        end
    end

    // Sticky error flags; a new rejection wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (wr_en_in & r_full)  | (r_ovf & ~err_clr_in);
            r_unf <= (rd_en_in & r_empty) | (r_unf & ~err_clr_in);
        end
    end

    assign data_o         = r_data;
    assign rd_valid_o     = r_rd_valid;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_af;
    assign almost_empty_o = r_ae;
    assign count_o        = r_count;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;
endmodule
